// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
// pcie_phy_pkg : shared PHY symbol, ordered-set and TS receiver definitions
// Rev 1.0 : initial release
// ============================================================================
package pcie_phy_pkg;

  typedef enum logic [7:0] {
    K28_5 = 8'hBC,
    PAD   = 8'hF7
  } phy_special_k_e;

  typedef enum logic [7:0] {
    TS1_ID = 8'h4A,
    TS2_ID = 8'h45
  } train_seq_e;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       dis_scramble;
    logic       loopback;
    logic       dis_link;
    logic       hot_reset;
  } training_ctrl_t;

  typedef struct packed {
    logic [7:0]      com;
    logic [7:0]      link_num;
    logic [7:0]      lane_num;
    logic [7:0]      n_fts;
    logic [7:0]      rate_id;
    training_ctrl_t  train_ctl;
    logic [9:0][7:0] ts_id;
  } pcie_tsos_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    ACCEPT  = 2'd2
  } tsos_rx_state_e;

  localparam int TSOS_LEN = 16;

  // Identical-TS compare used by the consecutive counter; n_fts deliberately ignored.
  function automatic logic tsos_match(input pcie_tsos_t a, input pcie_tsos_t b);
    return (a.ts_id[0] == b.ts_id[0]) && (a.link_num == b.link_num) &&
           (a.lane_num == b.lane_num) && (a.rate_id == b.rate_id) &&
           (a.train_ctl == b.train_ctl);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_tsos_rx_if.sv
`default_nettype none
// ============================================================================
// pcie_tsos_rx_if : symbol stream in, parsed TS ordered sets out
// Rev 1.0 : initial release
// ============================================================================
interface pcie_tsos_rx_if import pcie_phy_pkg::*; #(
  parameter int CONSEC_W = 4
);
  logic [7:0]          s_axis_tdata;
  logic                s_axis_tuser;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                cnt_clr;
  logic                ts_valid;
  pcie_tsos_t          ts_os;
  logic [CONSEC_W-1:0] ts_consec_cnt;
  logic                ts_error;

  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tvalid, cnt_clr,
    input  s_axis_tready, ts_valid, ts_os, ts_consec_cnt, ts_error
  );

  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tvalid, cnt_clr,
    output s_axis_tready, ts_valid, ts_os, ts_consec_cnt, ts_error
  );
endinterface
`default_nettype wire

// File: rtl/pcie_tsos_rx.sv
`default_nettype none
// ============================================================================
// pcie_tsos_rx : Gen1/2 single-lane TS1/TS2 receive parser with identical-TS count
// Rev 1.0 : initial release
// ============================================================================
module pcie_tsos_rx import pcie_phy_pkg::*; #(
  parameter int CONSEC_MAX = 8,
  parameter int CONSEC_W   = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pcie_tsos_rx_if.slave   bus
);

  localparam logic [CONSEC_W-1:0] c_cnt_max = CONSEC_W'(CONSEC_MAX);
  localparam logic [CONSEC_W-1:0] c_cnt_one = CONSEC_W'(1);
  localparam logic [3:0]          c_idx_last = 4'(TSOS_LEN - 1);

  tsos_rx_state_e      r_state;
  logic [3:0]          r_idx;
  logic [7:0]          r_link;
  logic [7:0]          r_lane;
  logic [7:0]          r_nfts;
  logic [7:0]          r_rate;
  training_ctrl_t      r_ctl;
  train_seq_e          r_type;
  pcie_tsos_t          r_prev;
  logic                r_prev_vld;
  logic [CONSEC_W-1:0] r_cnt;
  logic                r_ts_valid;
  logic                r_ts_error;
  pcie_tsos_t          r_ts_os;

  logic       w_k;
  logic [7:0] w_data;
  logic       w_com;
  logic       w_sym_ok;
  pcie_tsos_t w_ts_new;

  assign w_k    = bus.s_axis_tuser;
  assign w_data = bus.s_axis_tdata;
  assign w_com  = bus.s_axis_tvalid && w_k && (w_data == K28_5);

  always_comb begin
    w_sym_ok = 1'b0;
    case (r_idx)
      4'd1, 4'd2:       w_sym_ok = !w_k || (w_data == PAD);
      4'd3, 4'd4, 4'd5: w_sym_ok = !w_k;
      4'd6:             w_sym_ok = !w_k && ((w_data == TS1_ID) || (w_data == TS2_ID));
      default:          w_sym_ok = !w_k && (w_data == r_type);
    endcase
  end

  always_comb begin
    w_ts_new           = '0;
    w_ts_new.com       = K28_5;
    w_ts_new.link_num  = r_link;
    w_ts_new.lane_num  = r_lane;
    w_ts_new.n_fts     = r_nfts;
    w_ts_new.rate_id   = r_rate;
    w_ts_new.train_ctl = r_ctl;
    for (int i = 0; i < 10; i++) w_ts_new.ts_id[i] = r_type;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_idx      <= 4'd0;
      r_link     <= '0;
      r_lane     <= '0;
      r_nfts     <= '0;
      r_rate     <= '0;
      r_ctl      <= '0;
      r_type     <= TS1_ID;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_cnt      <= '0;
      r_ts_valid <= 1'b0;
      r_ts_error <= 1'b0;
      r_ts_os    <= '0;
    end else begin
      r_ts_valid <= 1'b0;
      r_ts_error <= 1'b0;
      if (bus.cnt_clr) r_cnt <= '0;
      case (r_state)
        HUNT: begin
          if (w_com) begin
            r_state <= COLLECT;
            r_idx   <= 4'd1;
          end
        end
        COLLECT: begin
          if (bus.s_axis_tvalid) begin
            if (w_com) begin
              // Early COM: abort the partial set but resynchronise on this COM.
              r_ts_error <= 1'b1;
              r_idx      <= 4'd1;
              r_cnt      <= '0;
            end else if (!w_sym_ok) begin
              r_ts_error <= 1'b1;
              r_state    <= HUNT;
              r_cnt      <= '0;
            end else begin
              case (r_idx)
                4'd1:    r_link <= w_data;
                4'd2:    r_lane <= w_data;
                4'd3:    r_nfts <= w_data;
                4'd4:    r_rate <= w_data;
                4'd5:    r_ctl  <= training_ctrl_t'(w_data);
                4'd6:    r_type <= train_seq_e'(w_data);
                default: ;
              endcase
              if (r_idx == c_idx_last) begin
                r_state    <= ACCEPT;
                r_ts_valid <= 1'b1;
                r_ts_os    <= w_ts_new;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end
          end
        end
        ACCEPT: begin
          // Count is settled here against the set just published on ts_os.
          if (bus.cnt_clr) begin
            r_cnt <= c_cnt_one;
          end else if (r_prev_vld && tsos_match(r_ts_os, r_prev)) begin
            r_cnt <= (r_cnt >= c_cnt_max) ? c_cnt_max : r_cnt + c_cnt_one;
          end else begin
            r_cnt <= c_cnt_one;
          end
          r_prev     <= r_ts_os;
          r_prev_vld <= 1'b1;
          if (w_com) begin
            r_state <= COLLECT;
            r_idx   <= 4'd1;
          end else begin
            r_state <= HUNT;
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign bus.s_axis_tready = !rst;
  assign bus.ts_valid      = r_ts_valid;
  assign bus.ts_error      = r_ts_error;
  assign bus.ts_os         = r_ts_os;
  assign bus.ts_consec_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tsos_rx.sv
`default_nettype none
// ============================================================================
// tb_pcie_tsos_rx : directed self-checking bench for pcie_tsos_rx
// Rev 1.0 : initial release
// ============================================================================
module tb_pcie_tsos_rx;
  import pcie_phy_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcie_tsos_rx_if #(.CONSEC_W(4)) bus();

  pcie_tsos_rx #(.CONSEC_MAX(8), .CONSEC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int v0, e0;
  logic [8:0]   sym [16];
  logic [127:0] exp_ts1, exp_ts2;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && bus.ts_valid) n_valid <= n_valid + 1;
    if (!rst && bus.ts_error) n_err   <= n_err + 1;
  end

  function automatic logic [127:0] mk_os(input logic [7:0] typ, link, lane, nfts, rate, ctl);
    return {8'hBC, link, lane, nfts, rate, ctl, {10{typ}}};
  endfunction

  task automatic load(input logic [7:0] typ, input logic lk, input logic [7:0] link,
                      input logic nk, input logic [7:0] lane,
                      input logic [7:0] nfts, rate, ctl);
    sym[0] = {1'b1, 8'hBC};
    sym[1] = {lk, link};
    sym[2] = {nk, lane};
    sym[3] = {1'b0, nfts};
    sym[4] = {1'b0, rate};
    sym[5] = {1'b0, ctl};
    for (int i = 6; i < 16; i++) sym[i] = {1'b0, typ};
  endtask

  task automatic put(input logic [8:0] s);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    {bus.s_axis_tuser, bus.s_axis_tdata} = s;
  endtask

  // Gap beats carry a COM pattern so a parser that ignores tvalid trips on them.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tuser  = 1'b1;
      bus.s_axis_tdata  = 8'hBC;
    end
  endtask

  // Returns 1 time unit after the edge that samples the last symbol.
  task automatic send(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
      put(sym[i]);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.cnt_clr       = 1'b0;
    exp_ts1 = mk_os(8'h4A, 8'hF7, 8'hF7, 8'h1F, 8'h06, 8'h00);
    exp_ts2 = mk_os(8'h45, 8'h03, 8'h00, 8'h20, 8'h06, 8'h08);

    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 128'(bus.s_axis_tready), 128'd0);
    check("rst_valid",  128'(bus.ts_valid), 128'd0);
    check("rst_error",  128'(bus.ts_error), 128'd0);
    check("rst_os",     bus.ts_os, 128'd0);
    check("rst_cnt",    128'(bus.ts_consec_cnt), 128'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("tready", 128'(bus.s_axis_tready), 128'd1);

    // 1: eight clean TS1 with PAD link/lane
    load(8'h4A, 1'b1, 8'hF7, 1'b1, 8'hF7, 8'h1F, 8'h06, 8'h00);
    for (int i = 0; i < 8; i++) begin
      send(0, 15, 1'b0);
      check("t1_valid", 128'(bus.ts_valid), 128'd1);
      tick();
      check("t1_cnt", 128'(bus.ts_consec_cnt), 128'(i + 1));
    end
    check("t1_os",    bus.ts_os, exp_ts1);
    check("t1_tsid0", 128'(bus.ts_os[7:0]), 128'h4A);
    check("t1_npulse", 128'(n_valid), 128'd8);

    // 2: four back-to-back identical TS1 saturate, then a TS2 restarts at 1
    for (int i = 0; i < 4; i++) begin
      send(0, 15, 1'b0);
      check("t2_valid", 128'(bus.ts_valid), 128'd1);
    end
    tick();
    check("t2_sat", 128'(bus.ts_consec_cnt), 128'd8);
    check("t2_npulse", 128'(n_valid), 128'd12);
    load(8'h45, 1'b0, 8'h03, 1'b0, 8'h00, 8'h20, 8'h06, 8'h08);
    send(0, 15, 1'b0);
    check("t2_ts2_valid", 128'(bus.ts_valid), 128'd1);
    tick();
    check("t2_ts2_cnt", 128'(bus.ts_consec_cnt), 128'd1);
    check("t2_ts2_os",  bus.ts_os, exp_ts2);

    // 3: bad ID at symbol 9
    v0 = n_valid; e0 = n_err;
    load(8'h4A, 1'b1, 8'hF7, 1'b1, 8'hF7, 8'h1F, 8'h06, 8'h00);
    sym[9] = {1'b0, 8'h45};
    send(0, 9, 1'b0);
    check("t3_err_pulse", 128'(bus.ts_error), 128'd1);
    send(10, 15, 1'b0);
    check("t3_no_valid", 128'(bus.ts_valid), 128'd0);
    tick();
    check("t3_nerr",   128'(n_err - e0), 128'd1);
    check("t3_nvalid", 128'(n_valid - v0), 128'd0);
    check("t3_cnt",    128'(bus.ts_consec_cnt), 128'd0);
    sym[9] = {1'b0, 8'h4A};
    send(0, 15, 1'b0);
    check("t3_good_valid", 128'(bus.ts_valid), 128'd1);
    tick();
    check("t3_good_cnt", 128'(bus.ts_consec_cnt), 128'd1);

    // 4: COM lands at idx10, TS2 continues from that COM
    v0 = n_valid; e0 = n_err;
    send(0, 9, 1'b0);
    load(8'h45, 1'b0, 8'h03, 1'b0, 8'h00, 8'h20, 8'h06, 8'h08);
    send(0, 15, 1'b0);
    check("t4_valid", 128'(bus.ts_valid), 128'd1);
    tick();
    check("t4_nerr",   128'(n_err - e0), 128'd1);
    check("t4_nvalid", 128'(n_valid - v0), 128'd1);
    check("t4_os",     bus.ts_os, exp_ts2);
    check("t4_cnt",    128'(bus.ts_consec_cnt), 128'd1);

    // 5: random gaps over three TS1 sets
    load(8'h4A, 1'b1, 8'hF7, 1'b1, 8'hF7, 8'h1F, 8'h06, 8'h00);
    for (int i = 0; i < 3; i++) begin
      send(0, 15, 1'b1);
      check("t5_valid", 128'(bus.ts_valid), 128'd1);
      tick();
      check("t5_cnt", 128'(bus.ts_consec_cnt), 128'(i + 1));
      check("t5_os",  bus.ts_os, exp_ts1);
    end

    // 6: cnt_clr during the ACCEPT cycle, then on its own
    send(0, 15, 1'b0);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    check("t6_clr_accept", 128'(bus.ts_consec_cnt), 128'd1);
    @(negedge clk) bus.cnt_clr = 1'b1;
    @(negedge clk) bus.cnt_clr = 1'b0;
    tick();
    check("t6_clr_alone", 128'(bus.ts_consec_cnt), 128'd0);

    // 7: reset mid-set
    v0 = n_valid; e0 = n_err;
    send(0, 6, 1'b0);
    rst = 1'b1;
    send(7, 15, 1'b0);
    @(negedge clk) rst = 1'b0;
    idle(3);
    tick();
    check("t7_nvalid", 128'(n_valid - v0), 128'd0);
    check("t7_nerr",   128'(n_err - e0), 128'd0);
    check("t7_cnt",    128'(bus.ts_consec_cnt), 128'd0);
    check("t7_os",     bus.ts_os, 128'd0);
    send(0, 15, 1'b0);
    check("t7_valid", 128'(bus.ts_valid), 128'd1);
    tick();
    check("t7_post_cnt", 128'(bus.ts_consec_cnt), 128'd1);
    check("t7_post_os",  bus.ts_os, exp_ts1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
